acc_seq: RTL and testbench
==========================

ACC_SEQ -- requirements
Module: acc_seq

Interface
REQ-001 SHALL have parameter XW, default 10, sample width.
REQ-002 SHALL have parameter AW, default 16, accumulator/sum width.
REQ-003 SHALL have parameter CW, default 8, block-length counter width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_b  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  request to begin one accumulation block; sampled only in IDLE.
REQ-007 SHALL have port n  input  CW  number of samples in the block; captured on start acceptance.
REQ-008 SHALL have port x_valid  input  1  sample x is valid this cycle.
REQ-009 SHALL have port x  input  XW  unsigned sample.
REQ-010 SHALL have port x_ready  output  1  block accepts a sample this cycle.
REQ-011 SHALL have port busy  output  1  high in states ACC and DONE.
REQ-012 SHALL have port done  output  1  one-cycle pulse; sum is final.
REQ-013 SHALL have port ovf  output  1  sticky: block sum exceeded 2^AW-1.
REQ-014 SHALL have port sum  output  AW  accumulator value, registered.

Function
REQ-015 SHALL implement FSM states IDLE, ACC, DONE; all outputs driven from registers or decoded from state only (no combinational path from inputs to outputs).
REQ-016 SHALL, in IDLE with start=1, on that edge: capture n into remaining counter, clear sum to 0, clear ovf to 0; go to ACC if n!=0, else go to DONE.
REQ-017 SHALL, in IDLE with start=0, hold sum, ovf and state unchanged.
REQ-018 SHALL assert x_ready=1 exactly while in ACC; x_ready=0 in IDLE and DONE.
REQ-019 SHALL count a handshake only when x_valid=1 and x_ready=1 in the same cycle; cycles with x_valid=0 leave sum and counter unchanged.
REQ-020 SHALL, on each handshake, update sum <= (sum + zero-extended x) mod 2^AW and decrement remaining by 1.
REQ-021 SHALL set ovf=1 on any handshake whose AW+1-bit addition carries out; ovf stays 1 until next start acceptance or reset.
REQ-022 SHALL go ACC->DONE on the handshake that takes remaining from 1 to 0; no further samples accepted.
REQ-023 SHALL assert done=1 for exactly the one cycle spent in DONE, then go DONE->IDLE unconditionally.
REQ-024 SHALL present the final sum in the done cycle (latency: one cycle after the last handshake) and hold it in IDLE until the next start acceptance.
REQ-025 SHALL ignore start while in ACC or DONE (no restart, no counter reload).
REQ-026 SHALL treat n=2^CW-1 as the maximum block length with no counter wrap.

Reset
REQ-027 SHALL, while rst_b=0 (asynchronously, including mid-block), force state=IDLE, sum=0, remaining=0, ovf=0, done=0, busy=0, x_ready=0.
REQ-028 SHALL resume normal operation on the first rising clk edge after rst_b returns to 1, with no partial block retained.

Verification
REQ-029 SHALL pass: rst_b=0 for first 25 time units of a 100-unit clock -> sum=0, done=0, busy=0, x_ready=0, ovf=0 throughout reset.
REQ-030 SHALL pass: start with n=4, x=1,4,7,10 with x_valid=1 back-to-back -> done pulses one cycle after 4th handshake, sum=22, ovf=0, then IDLE with sum held at 22.
REQ-031 SHALL pass: n=3, x=5 with x_valid toggled 1,0,1,0,1 -> exactly 3 handshakes counted, sum=15, done one cycle after the third.
REQ-032 SHALL pass: n=70, x=1023 every cycle -> sum=6074 (71610 mod 65536), ovf=1 at done; next start clears ovf to 0 and sum to 0.
REQ-033 SHALL pass: start with n=0 -> DONE next cycle, done=1, sum=0, x_ready never asserted.
REQ-034 SHALL pass: start re-asserted during ACC, then rst_b=0 after 2 of 5 samples -> start ignored, all outputs zero immediately on reset, IDLE after release.

Source files
------------

// File: rtl/acc_seq.sv
// Purpose : accumulates a block of n unsigned samples into a registered sum with a sticky overflow flag.
// Latency : sum is final and done pulses in the cycle right after the last sample handshake (n=0: the cycle after start).
// Backpressure: x_ready is high only in ACC; upstream stalls freely via x_valid, start is ignored while busy.
//
// Ports:
//   clk      in   core clock, all state updates on the rising edge
//   rst_b    in   asynchronous active-low reset
//   start    in   begin one block; sampled only in IDLE
//   n        in   [CW] block length, captured when start is accepted
//   x_valid  in   sample valid
//   x        in   [XW] unsigned sample
//   x_ready  out  block accepts a sample this cycle (state ACC)
//   busy     out  block in progress (states ACC and DONE)
//   done     out  one-cycle pulse, sum is final
//   ovf      out  sticky carry-out of the block sum
//   sum      out  [AW] registered accumulator (mod 2^AW)
module acc_seq #(
    parameter int XW = 10,
    parameter int AW = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          start,
    input  logic [CW-1:0] n,
    input  logic          x_valid,
    input  logic [XW-1:0] x,
    output logic          x_ready,
    output logic          busy,
    output logic          done,
    output logic          ovf,
    output logic [AW-1:0] sum
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [CW-1:0] r_rem;
    logic [AW-1:0] r_sum;
    logic          r_ovf;

    logic          w_start_acc;
    logic          w_hs;
    logic          w_last;
    logic [AW:0]   w_x_ext;
    logic [AW:0]   w_add;

    // Start is only honoured in IDLE; a sample only counts in ACC.
    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_hs        = (r_state == S_ACC) && x_valid;
    // remaining is never 0 while in ACC, so the 1->0 step is the last sample.
    assign w_last      = w_hs && (r_rem == CW'(1));

    // One extra bit on the adder: its MSB is the carry-out that sets ovf.
    assign w_x_ext = (AW+1)'(x);
    assign w_add   = {1'b0, r_sum} + w_x_ext;

    //--------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    // n=0 is an empty block: report it straight away.
                    w_state_nxt = (n != '0) ? S_ACC : S_DONE;
                end
            end
            S_ACC: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------
    // Outputs decoded from state only, so no input-to-output comb path
    //--------------------------------------------------------------------
    always_comb begin
        x_ready = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (r_state)
            S_ACC: begin
                x_ready = 1'b1;
                busy    = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                x_ready = 1'b0;
            end
        endcase
    end

    //--------------------------------------------------------------------
    // Datapath: remaining count, accumulator, sticky overflow
    //--------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_rem <= '0;
            r_sum <= '0;
            r_ovf <= 1'b0;
        end else if (w_start_acc) begin
            r_rem <= n;
            r_sum <= '0;
            r_ovf <= 1'b0;
        end else if (w_hs) begin
            r_rem <= r_rem - CW'(1);
            r_sum <= w_add[AW-1:0];
            r_ovf <= r_ovf | w_add[AW];
        end
    end

    assign sum = r_sum;
    assign ovf = r_ovf;

endmodule

// File: tb/tb_acc_seq.sv
// Purpose : randomized + directed scoreboard bench for acc_seq.
// Latency : expects done in the cycle right after the final handshake edge (start edge when n=0).
// Backpressure: drives x_valid with random gaps; start pulses only while IDLE except in the ignore test.
module tb_acc_seq;

    localparam int XW = 10;
    localparam int AW = 16;
    localparam int CW = 8;

    logic          clk;
    logic          rst_b;
    logic          start;
    logic [CW-1:0] n;
    logic          x_valid;
    logic [XW-1:0] x;
    logic          x_ready;
    logic          busy;
    logic          done;
    logic          ovf;
    logic [AW-1:0] sum;

    acc_seq #(.XW(XW), .AW(AW), .CW(CW)) dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .start   (start),
        .n       (n),
        .x_valid (x_valid),
        .x       (x),
        .x_ready (x_ready),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf),
        .sum     (sum)
    );

    // 100-unit clock, first rising edge at t=50
    initial clk = 1'b0;
    always #50 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint exp_sum;
        int     exp_ovf;
        int     exp_cyc;
    } exp_t;

    exp_t   sb_q[$];
    int     checks = 0;
    int     errors = 0;
    int     n_pushed = 0;
    int     n_popped = 0;

    // stimulus tables for directed blocks; empty -> random
    int     xq[$];
    int     vq[$];

    task automatic chk(input string nm, input longint act, input longint exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_sum"},     sum,     0);
        chk({nm, "_done"},    done,    0);
        chk({nm, "_busy"},    busy,    0);
        chk({nm, "_x_ready"}, x_ready, 0);
        chk({nm, "_ovf"},     ovf,     0);
    endtask

    // Monitor: every done pulse consumes one expectation.
    always @(negedge clk) begin
        if (rst_b && done) begin
            if (sb_q.size() == 0) begin
                chk("done_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                n_popped++;
                chk("done_sum", sum, e.exp_sum);
                chk("done_ovf", ovf, e.exp_ovf);
                chk("done_cycle", cyc, e.exp_cyc);
            end
        end
    end

    // Runs one complete block of nn samples; xq/vq give x values and
    // x_valid pattern, anything missing is randomized.
    task automatic run_block(input int nn, output longint final_sum);
        longint tot;
        int     k;
        int     it;
        int     vi;
        int     v;
        int     xv;
        exp_t   e;
        tot = 0; k = 0; it = 0; vi = 0;
        @(posedge clk); #1;
        start = 1'b1;
        n     = CW'(nn);
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_sum_clear", sum, 0);
        chk("start_ovf_clear", ovf, 0);
        while (k < nn && it < 3000) begin
            v  = (vi < vq.size()) ? vq[vi] : (($urandom % 4) != 0 ? 1 : 0);
            vi++;
            xv = (k < xq.size()) ? xq[k] : int'($urandom % 1024);
            x_valid = v[0];
            x       = XW'(xv);
            chk("x_ready_in_acc", x_ready, 1);
            @(posedge clk); #1;
            if (v != 0) begin
                tot += xv;
                k++;
            end
            it++;
        end
        x_valid = 1'b0;
        if (it >= 3000) chk("block_timeout", it, 0);
        // Now in DONE: the expected result is sum of all accepted samples.
        e.exp_sum = tot % (64'd1 << AW);
        e.exp_ovf = (tot > ((64'd1 << AW) - 1)) ? 1 : 0;
        e.exp_cyc = cyc;
        sb_q.push_back(e);
        n_pushed++;
        final_sum = e.exp_sum;
        chk("x_ready_done", x_ready, 0);
        chk("busy_done", busy, 1);
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_sum_hold", sum, final_sum);
        @(posedge clk); #1;
        chk("idle_sum_hold2", sum, final_sum);
        xq.delete();
        vq.delete();
    endtask

    initial begin
        longint fs;
        rst_b = 1'b0; start = 1'b0; n = '0; x_valid = 1'b0; x = '0;
        #5;  chk_all_zero("rst_t5");
        #15; chk_all_zero("rst_t20");
        #5;  rst_b = 1'b1;

        // back-to-back 1,4,7,10 -> 22
        xq = '{1, 4, 7, 10}; vq = '{1, 1, 1, 1};
        run_block(4, fs);
        chk("dir_sum22", fs, 22);

        // toggled valid, 3 x 5 -> 15
        xq = '{5, 5, 5}; vq = '{1, 0, 1, 0, 1};
        run_block(3, fs);
        chk("dir_sum15", fs, 15);

        // 70 x 1023 -> 6074 with overflow
        for (int i = 0; i < 70; i++) begin xq.push_back(1023); vq.push_back(1); end
        run_block(70, fs);
        chk("dir_sum6074", fs, 6074);

        // empty block: done next cycle, sum 0
        run_block(0, fs);

        // max block length, no counter wrap
        for (int i = 0; i < 255; i++) xq.push_back(1023);
        run_block(255, fs);

        // random blocks
        for (int b = 0; b < 20; b++) begin
            run_block(int'($urandom_range(0, 24)), fs);
        end

        // start ignored during ACC, then async reset mid-block
        @(posedge clk); #1;
        start = 1'b1; n = CW'(5);
        @(posedge clk); #1;
        n = CW'(1);                       // start stays high with a different n
        for (int i = 0; i < 2; i++) begin
            x_valid = 1'b1; x = XW'(300 + i);
            @(posedge clk); #1;
        end
        chk("ignore_start_x_ready", x_ready, 1);
        chk("ignore_start_busy", busy, 1);
        chk("ignore_start_sum", sum, 601);
        start = 1'b0; x_valid = 1'b0;
        #20;
        rst_b = 1'b0;
        #1;
        chk_all_zero("midblock_rst");
        @(posedge clk); #10;
        chk_all_zero("rst_held");
        rst_b = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_x_ready", x_ready, 0);
        chk("post_rst_sum", sum, 0);

        // normal operation resumes
        xq = '{2, 3}; vq = '{1, 1};
        run_block(2, fs);
        chk("resume_sum", fs, 5);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb_q.size(), 0);
        chk("done_count", n_popped, n_pushed);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog_timeout actual=%0d expected=0", cyc);
        $fatal(1, "watchdog");
    end

endmodule
